// File: rtl/fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rr_scheduler
// Purpose  : Round-robin scheduler that drains NUM_SRC first-word-fall-through
//            source FIFOs into one shared destination FIFO. Each grant moves
//            at most BURST words, and one IDLE cycle separates grants.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rr_scheduler #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 32,
  parameter int BURST   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_SRC-1:0]       SRC_EMP,
  input  logic [NUM_SRC*WIDTH-1:0] SRC_DOT,
  output logic [NUM_SRC-1:0]       SRC_DEQ,
  input  logic                     DST_FUL,
  output logic                     DST_ENQ,
  output logic [WIDTH-1:0]         DST_DIN,
  output logic [NUM_SRC-1:0]       GRANT,
  output logic                     BUSY,
  output logic [31:0]              XFER_CNT
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [BW-1:0] c_LAST_BEAT = BW'(BURST - 1);
  localparam logic [IW-1:0] c_LAST_SRC  = IW'(NUM_SRC - 1);
  localparam logic [IW:0]   c_NUM_SRC   = (IW+1)'(NUM_SRC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_XFER = 1'b1
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_ptr;
  logic [BW-1:0]        r_beat;
  logic [NUM_SRC-1:0]   r_grant;
  logic                 r_busy;
  logic [31:0]          r_xfer_cnt;

  logic                 w_emp_g;
  logic [WIDTH-1:0]     w_dot_g;
  logic                 w_xfer;
  logic                 w_pick_vld;
  logic [IW-1:0]        w_pick_idx;
  logic [NUM_SRC-1:0]   w_pick_oh;
  logic [IW-1:0]        w_next_ptr;
  logic                 w_exit;

  // Select the empty flag and head word of the currently granted source.
  always_comb begin
    w_emp_g = 1'b1;
    w_dot_g = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_gidx == IW'(i)) begin
        w_emp_g = SRC_EMP[i];
        w_dot_g = SRC_DOT[i*WIDTH +: WIDTH];
      end
    end
  end

  // A word moves only in XFER with data available and room downstream;
  // reset masks the strobes so nothing is lost while RST is held.
  assign w_xfer = (r_state == S_XFER) & ~w_emp_g & ~DST_FUL & ~RST;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_deq
      assign SRC_DEQ[gi] = w_xfer & (r_gidx == IW'(gi));
    end
  endgenerate

  assign DST_ENQ = w_xfer;
  assign DST_DIN = (r_state == S_XFER) ? w_dot_g : '0;

  // Find the first non-empty source starting at the round-robin pointer.
  always_comb begin
    logic [IW:0] w_sum;
    w_sum      = '0;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= c_NUM_SRC) begin
        w_sum = w_sum - c_NUM_SRC;
      end
      if (!w_pick_vld && !SRC_EMP[w_sum[IW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_sum[IW-1:0];
      end
    end
    w_pick_oh = NUM_SRC'(1) << w_pick_idx;
  end

  assign w_next_ptr = (r_gidx == c_LAST_SRC) ? '0 : r_gidx + IW'(1);

  // Burst ends on its last beat, or as soon as the granted source runs dry
  // (empty wins over a simultaneous full).
  assign w_exit = (w_xfer && (r_beat == c_LAST_BEAT)) || w_emp_g;

  // Scheduler state machine, grant register and transfer counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_gidx     <= '0;
      r_ptr      <= '0;
      r_beat     <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_state <= S_XFER;
            r_gidx  <= w_pick_idx;
            r_grant <= w_pick_oh;
            r_beat  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_XFER: begin
          if (w_xfer) begin
            r_beat     <= r_beat + BW'(1);
            r_xfer_cnt <= r_xfer_cnt + 32'd1;
          end
          if (w_exit) begin
            r_state <= S_IDLE;
            r_ptr   <= w_next_ptr;
            r_grant <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign GRANT    = r_grant;
  assign BUSY     = r_busy;
  assign XFER_CNT = r_xfer_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rr_scheduler
// Purpose  : Self-checking bench for fifo_rr_scheduler. Source FIFOs are
//            queues in the bench; a cycle-level model of the scheduling rules
//            predicts every strobe, grant and counter value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rr_scheduler;

  localparam int NUM_SRC = 4;
  localparam int WIDTH   = 32;
  localparam int BURST   = 4;

  logic                     CLK;
  logic                     RST;
  logic [NUM_SRC-1:0]       SRC_EMP;
  logic [NUM_SRC*WIDTH-1:0] SRC_DOT;
  logic [NUM_SRC-1:0]       SRC_DEQ;
  logic                     DST_FUL;
  logic                     DST_ENQ;
  logic [WIDTH-1:0]         DST_DIN;
  logic [NUM_SRC-1:0]       GRANT;
  logic                     BUSY;
  logic [31:0]              XFER_CNT;

  fifo_rr_scheduler #(
    .NUM_SRC (NUM_SRC),
    .WIDTH   (WIDTH),
    .BURST   (BURST)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .SRC_EMP  (SRC_EMP),
    .SRC_DOT  (SRC_DOT),
    .SRC_DEQ  (SRC_DEQ),
    .DST_FUL  (DST_FUL),
    .DST_ENQ  (DST_ENQ),
    .DST_DIN  (DST_DIN),
    .GRANT    (GRANT),
    .BUSY     (BUSY),
    .XFER_CNT (XFER_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int                 n_chk;
  int                 n_fail;
  logic [WIDTH-1:0]   q [NUM_SRC][$];
  int                 seq;
  // behavioural model: granted source (-1 = idle), pointer, beats, count
  int                 m_g;
  int                 m_ptr;
  int                 m_beats;
  logic [31:0]        m_cnt;
  logic               last_enq;
  logic [NUM_SRC-1:0] prev_grant;
  int                 order[$];
  logic [15:0]        pat;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic push_words(input int s, input int n);
    for (int j = 0; j < n; j++) begin
      q[s].push_back({8'(s), 24'(seq)});
      seq++;
    end
  endtask

  function automatic int oh2idx(input logic [NUM_SRC-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NUM_SRC; i++) if (v[i]) r = i;
    return r;
  endfunction

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic step(input logic rst_v, input logic ful_v);
    logic [NUM_SRC-1:0]       emp;
    logic [NUM_SRC*WIDTH-1:0] dot;
    logic                     xp;
    logic [NUM_SRC-1:0]       exp_oh;
    logic [WIDTH-1:0]         exp_din;
    int                       g;
    for (int i = 0; i < NUM_SRC; i++) begin
      emp[i] = (q[i].size() == 0);
      if (emp[i]) dot[i*WIDTH +: WIDTH] = $urandom;
      else        dot[i*WIDTH +: WIDTH] = q[i][0];
    end
    RST     = rst_v;
    DST_FUL = ful_v;
    SRC_EMP = emp;
    SRC_DOT = dot;
    #2;
    g       = m_g;
    xp      = 1'b0;
    exp_oh  = '0;
    exp_din = '0;
    if (g >= 0) begin
      xp      = !rst_v && !emp[g] && !ful_v;
      exp_oh  = NUM_SRC'(1) << g;
      exp_din = dot[g*WIDTH +: WIDTH];
    end
    chk_eq("DST_ENQ",  32'(DST_ENQ), 32'(xp));
    chk_eq("SRC_DEQ",  32'(SRC_DEQ), xp ? 32'(exp_oh) : 32'd0);
    chk_eq("DST_DIN",  DST_DIN, exp_din);
    chk_eq("GRANT",    32'(GRANT), 32'(exp_oh));
    chk_eq("BUSY",     32'(BUSY), 32'(g >= 0));
    chk_eq("XFER_CNT", XFER_CNT, m_cnt);
    last_enq = DST_ENQ;
    if (GRANT != '0 && prev_grant == '0) order.push_back(oh2idx(GRANT));
    prev_grant = GRANT;
    if (rst_v) begin
      m_g = -1; m_ptr = 0; m_beats = 0; m_cnt = '0;
    end else if (g < 0) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        int idx;
        idx = (m_ptr + k) % NUM_SRC;
        if (m_g < 0 && !emp[idx]) begin
          m_g = idx;
          m_beats = 0;
        end
      end
    end else if (xp) begin
      void'(q[g].pop_front());
      m_beats++;
      m_cnt++;
      if (m_beats == BURST) begin
        m_ptr = (g + 1) % NUM_SRC;
        m_g   = -1;
      end
    end else if (emp[g]) begin
      m_ptr = (g + 1) % NUM_SRC;
      m_g   = -1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; seq = 0;
    m_g = -1; m_ptr = 0; m_beats = 0; m_cnt = '0;
    prev_grant = '0;
    RST = 1'b1; DST_FUL = 1'b0; SRC_EMP = '1; SRC_DOT = '0;
    @(posedge CLK);
    #1;

    // reset state
    step(1'b1, 1'b0);

    // single source, 10 words: ENQ 4 on, 1 off, 4 on, 1 off, 2 on
    push_words(0, 10);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0);
      pat[i] = last_enq;
    end
    chk_eq("t1_enq_pattern", 32'(pat), 32'h0000_1BDE);
    chk_eq("t1_xfer_cnt", XFER_CNT, 32'd10);
    chk_eq("t1_src0_drained", 32'(q[0].size()), 32'd0);

    // all four sources with 8 words: grant order 0,1,2,3,0,1,2,3
    step(1'b1, 1'b0);
    for (int s = 0; s < NUM_SRC; s++) push_words(s, 8);
    order.delete();
    for (int i = 0; i < 45; i++) step(1'b0, 1'b0);
    chk_eq("t2_num_bursts", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < order.size()) chk_eq("t2_grant_order", 32'(order[i]), 32'(i % NUM_SRC));
    end
    chk_eq("t2_xfer_cnt", XFER_CNT, 32'd32);

    // destination backpressure on src1 after its 2nd word
    step(1'b1, 1'b0);
    push_words(1, 6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    chk_eq("t3_xfer_cnt", XFER_CNT, 32'd6);

    // src2 drains mid-burst, then src0 is served next
    step(1'b1, 1'b0);
    push_words(2, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    push_words(0, 2);
    push_words(1, 2);
    order.delete();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk_eq("t4_first_grant", 32'(order.size() > 0 ? order[0] : -1), 32'd0);

    // reset during the 3rd beat of a src0 burst
    step(1'b1, 1'b0);
    for (int s = 0; s < NUM_SRC; s++) q[s].delete();
    step(1'b0, 1'b0);
    push_words(0, 8);
    push_words(3, 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk_eq("t5_grant_after_rst", 32'(GRANT), 32'd0);
    chk_eq("t5_busy_after_rst", 32'(BUSY), 32'd0);
    chk_eq("t5_cnt_after_rst", XFER_CNT, 32'd0);
    order.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    chk_eq("t5_restart_grant", 32'(order.size() > 0 ? order[0] : -1), 32'd0);

    // counter wrap from a preloaded value
    step(1'b1, 1'b0);
    for (int s = 0; s < NUM_SRC; s++) q[s].delete();
    step(1'b0, 1'b0);
    force dut.r_xfer_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_xfer_cnt;
    m_cnt = 32'hFFFF_FFFE;
    push_words(1, 3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    chk_eq("t6_cnt_wrap", XFER_CNT, 32'd1);

    // randomized traffic, backpressure and occasional reset
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 4) == 0) push_words(int'($urandom % NUM_SRC), int'(1 + $urandom % 3));
      step(($urandom % 400) == 0, ($urandom % 4) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
